cla_share_sequencer: RTL



---
 rtl/cla_share_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cla_share_sequencer.sv
// cla_share_sequencer
//   Shares one 8-bit carry-lookahead adder slice between two requesters to
//   perform WIDTH-bit additions, one byte per cycle, least-significant byte
//   first. The carry between bytes is held in a register. Arbitration is
//   round-robin. Results go out on a valid/ready response port.
//
// Ports
//   clk, resetn                  clock; asynchronous active-low reset
//   reqN_valid/ready             request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_cin     operands and carry-in for requester N
//   rsp_valid/ready              response handshake
//   rsp_sum                      a + b + cin, modulo 2^WIDTH
//   rsp_cout                     carry out of the MSB
//   rsp_ovf                      signed overflow
//   rsp_id                       requester that issued the operation
//
// WIDTH must be a multiple of 8.

// 8-bit carry-lookahead slice. It produces the sum, a group generate and a
// group propagate. Group carry-out = g | (p & cin).
module cla8_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       g,
  output logic       p
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [7:0] carry;
  logic       gg;
  logic       pp;

  // Each bit's carry-in is a flat function of the lower bits' generate and
  // propagate terms and the slice carry-in. It does not depend on the
  // previous bit's carry.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop
    // assignment, so synthesis never infers a latch here.
    gen   = a & b;
    prop  = a ^ b;
    carry = '0;
    gg    = 1'b0;
    pp    = 1'b1;
    g     = 1'b0;
    p     = 1'b1;
    carry[0] = cin;
    for (int i = 1; i < 8; i++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < i; j++) begin
        gg = gen[j] | (prop[j] & gg);
        pp = pp & prop[j];
      end
      carry[i] = gg | (pp & cin);
    end
    for (int j = 0; j < 8; j++) begin
      g = gen[j] | (prop[j] & g);
      p = p & prop[j];
    end
    s = prop ^ carry;
  end

endmodule

module cla_share_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_id
);

  localparam int N      = WIDTH / 8;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              cin_q;
  logic              id_q;
  logic              last_grant_q;

  logic              grant_valid;
  logic              grant_id;

  logic [7:0]        slice_a, slice_b, slice_s;
  logic              slice_cin, slice_g, slice_p, slice_cout;

  // Select the current byte of the latched operands.
  assign slice_a    = 8'(a_q >> {beat_q, 3'b000});
  assign slice_b    = 8'(b_q >> {beat_q, 3'b000});
  assign slice_cin  = (beat_q == '0) ? cin_q : carry_q;
  assign slice_cout = slice_g | (slice_p & slice_cin);

  cla8_slice u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (slice_cin),
    .s   (slice_s),
    .g   (slice_g),
    .p   (slice_p)
  );

  // Grant and next-state logic. resetn gates the grant so that neither
  // ready signal is asserted while reset is held.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    state_d     = state_q;
    if (state_q == IDLE && resetn) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
    case (state_q)
      IDLE:    if (grant_valid)          state_d = RUN;
      RUN:     if (beat_q == LAST_BEAT)  state_d = DONE;
      DONE:    if (rsp_ready)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  assign req0_ready = grant_valid & ~grant_id;
  assign req1_ready = grant_valid &  grant_id;
  assign rsp_valid  = (state_q == DONE);
  assign rsp_id     = id_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_q       <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;   // requester 0 wins the first tie
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_ovf      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            a_q          <= grant_id ? req1_a   : req0_a;
            b_q          <= grant_id ? req1_b   : req0_b;
            cin_q        <= grant_id ? req1_cin : req0_cin;
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            beat_q       <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < N; k++) begin
            if (beat_q == BEAT_W'(k)) rsp_sum[k*8 +: 8] <= slice_s;
          end
          carry_q <= slice_cout;
          if (beat_q == LAST_BEAT) begin
            beat_q   <= '0;
            rsp_cout <= slice_cout;
            // The MSB of the sum is produced in this same beat.
            rsp_ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                        (slice_s[7] != a_q[WIDTH-1]);
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
